bus_arbiter: RTL and testbench

//  Sequences the shared serial bus between masters M1/M2 and slaves S1-S3.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_timeout_counter.sv | 45 ++++
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus arbiter.
//   bus_state_e   : arbiter FSM states (IDLE / BUSY / TURN)
//   master_sel_t  : 3-bit master select code driven to the interconnect
//   slave_sel_t   : 3-bit slave select code driven to the interconnect
//   SEL_*         : select-code constants (0 always means "nobody selected")
//   slave_id_valid: legal target check for a requested slave ID
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } bus_state_e;

    typedef logic [2:0] master_sel_t;
    typedef logic [2:0] slave_sel_t;

    localparam master_sel_t SEL_NONE = 3'd0;
    localparam master_sel_t SEL_M1   = 3'd1;
    localparam master_sel_t SEL_M2   = 3'd2;
    localparam slave_sel_t  SEL_S1   = 3'd1;
    localparam slave_sel_t  SEL_S2   = 3'd2;
    localparam slave_sel_t  SEL_S3   = 3'd3;

    // Slave IDs are 1-based; 0 is the "none" code and can never be a target.
    function automatic logic slave_id_valid(input logic [2:0] id, input int num_slaves);
        return (id != 3'd0) && (int'(id) <= num_slaves);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog counter for a single bus tenure.
//   clk     : clock, rising edge
//   rstN    : synchronous reset, active-low
//   clear   : force count back to zero (has priority over enable)
//   enable  : advance the count by one this cycle
//   expire  : high while enabled and the count sits at TIMEOUT-1, i.e. during
//             the TIMEOUT-th enabled cycle since the last clear
// The count saturates at TIMEOUT-1 rather than wrapping, so a missed clear can
// never make the watchdog silently re-arm.
module bus_timeout_counter #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LAST)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus.
//   clk        : clock, rising edge
//   rstN       : synchronous reset, active-low
//   m_req      : per-master level request, held until granted
//   m_slave_id : per-master target slave code, only looked at while arbitrating
//   m_done     : per-master release pulse, only the owner's bit is honoured
//   m_grant    : registered one-hot grant to the current owner
//   m_err      : registered 1-cycle pulse: bad slave ID rejected, or watchdog fired
//   master     : registered master select code (0 = none, i+1 = master i)
//   slave      : registered slave select code  (0 = none, 1..NUM_SLAVES)
// A tenure runs IDLE -> BUSY -> TURN -> IDLE; TURN is the one idle
// turnaround cycle between owners. Every output comes straight from a flop.
import bus_pkg::*;

module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0][2:0] m_slave_id,
    input  logic [NUM_MASTERS-1:0]      m_done,
    output logic [NUM_MASTERS-1:0]      m_grant,
    output logic [NUM_MASTERS-1:0]      m_err,
    output master_sel_t                 master,
    output slave_sel_t                  slave
);

    bus_state_e                 state_reg,  state_next;
    logic [NUM_MASTERS-1:0]     grant_reg,  grant_next;
    logic [NUM_MASTERS-1:0]     err_reg,    err_next;
    master_sel_t                master_reg, master_next;
    slave_sel_t                 slave_reg,  slave_next;
    // Index of the most recently granted master; the search for the next
    // winner starts just after it. Reset points at the last master so that
    // master 1 wins the first tie.
    logic [2:0]                 last_idx_reg, last_idx_next;

    logic [NUM_MASTERS-1:0]     id_ok;
    logic [NUM_MASTERS-1:0]     cand;
    logic [NUM_MASTERS-1:0]     rejected;

    logic                       win_found;
    logic [2:0]                 win_idx;
    logic [NUM_MASTERS-1:0]     win_onehot;
    slave_sel_t                 win_slave;

    logic                       owner_done;
    logic                       expire;

    // ------------------------------------------------------------------
    // Request qualification: only requests with a legal target compete.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_id_check
        assign id_ok[gi]    = slave_id_valid(m_slave_id[gi], NUM_SLAVES);
        assign cand[gi]     = m_req[gi] &  id_ok[gi];
        assign rejected[gi] = m_req[gi] & ~id_ok[gi];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: walk the masters starting one past the last winner
    // and take the first qualified candidate.
    // ------------------------------------------------------------------
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_slave  = SEL_NONE;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!win_found && cand[j] &&
                    (j == ((int'(last_idx_reg) + k) % NUM_MASTERS))) begin
                    win_found     = 1'b1;
                    win_idx       = 3'(j);
                    win_onehot[j] = 1'b1;
                    win_slave     = m_slave_id[j];
                end
            end
        end
    end

    // Release requests from anyone but the owner are ignored.
    assign owner_done = |(m_done & grant_reg);

    // ------------------------------------------------------------------
    // Tenure watchdog: runs only while BUSY, cleared everywhere else.
    // ------------------------------------------------------------------
    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rstN   (rstN),
        .clear  (state_reg != ST_BUSY),
        .enable (state_reg == ST_BUSY),
        .expire (expire)
    );

    // ------------------------------------------------------------------
    // FSM and output next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        master_next   = master_reg;
        slave_next    = slave_reg;
        last_idx_next = last_idx_reg;
        err_next      = '0;

        case (state_reg)
            ST_IDLE: begin
                // A rejected requester is flagged every cycle it keeps
                // asking with a bad ID, independent of who else wins.
                err_next    = rejected;
                grant_next  = '0;
                master_next = SEL_NONE;
                slave_next  = SEL_NONE;
                if (win_found) begin
                    state_next    = ST_BUSY;
                    grant_next    = win_onehot;
                    master_next   = win_idx + 3'd1;
                    slave_next    = win_slave;
                    last_idx_next = win_idx;
                end
            end

            ST_BUSY: begin
                // Selects stay frozen; requests and IDs are not looked at.
                // A release in the watchdog's final cycle counts as a clean
                // release, so done is tested first.
                if (owner_done || expire) begin
                    state_next  = ST_TURN;
                    grant_next  = '0;
                    master_next = SEL_NONE;
                    slave_next  = SEL_NONE;
                    if (!owner_done) begin
                        err_next = grant_reg;
                    end
                end
            end

            ST_TURN: begin
                state_next  = ST_IDLE;
                grant_next  = '0;
                master_next = SEL_NONE;
                slave_next  = SEL_NONE;
            end

            default: begin
                state_next  = ST_IDLE;
                grant_next  = '0;
                master_next = SEL_NONE;
                slave_next  = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            err_reg      <= '0;
            master_reg   <= SEL_NONE;
            slave_reg    <= SEL_NONE;
            last_idx_reg <= 3'(NUM_MASTERS - 1);
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            err_reg      <= err_next;
            master_reg   <= master_next;
            slave_reg    <= slave_next;
            last_idx_reg <= last_idx_next;
        end
    end

    assign m_grant = grant_reg;
    assign m_err   = err_reg;
    assign master  = master_reg;
    assign slave   = slave_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (TIMEOUT shortened to 8).
// A transaction-level reference model (owner, cycles held, pending turnaround,
// last winner) predicts the registered outputs after every clock edge.
module tb_bus_arbiter;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic [1:0]       m_req = '0;
    logic [1:0][2:0]  m_slave_id = '0;
    logic [1:0]       m_done = '0;
    logic [1:0]       m_grant;
    logic [1:0]       m_err;
    logic [2:0]       master;
    logic [2:0]       slave;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // reference model state
    int         own       = 0;   // owning master number, 0 = none
    int         own_slave = 0;
    int         held      = 0;   // BUSY cycles completed by current owner
    bit         gap       = 0;   // turnaround cycle still to come
    int         last      = NM;  // last winner, reset so master 1 wins a tie
    logic [1:0] exp_err   = '0;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .m_req      (m_req),
        .m_slave_id (m_slave_id),
        .m_done     (m_done),
        .m_grant    (m_grant),
        .m_err      (m_err),
        .master     (master),
        .slave      (slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic bit id_legal(input logic [2:0] id);
        return (id >= 3'd1) && (int'(id) <= NS);
    endfunction

    // Apply the arbitration rules to the inputs seen at this edge.
    task automatic model_edge();
        bit found;
        exp_err = '0;
        if (!rstN) begin
            own = 0; own_slave = 0; held = 0; gap = 0; last = NM;
        end else if (own != 0) begin
            held++;
            if (m_done[own-1]) begin
                own = 0; gap = 1;
            end else if (held == TO) begin
                exp_err[own-1] = 1'b1;
                own = 0; gap = 1;
            end
        end else if (gap) begin
            gap = 0;
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (m_req[i] && !id_legal(m_slave_id[i])) exp_err[i] = 1'b1;
            end
            found = 0;
            for (int k = 1; k <= NM; k++) begin
                int m;
                m = ((last + k - 1) % NM) + 1;
                if (!found && m_req[m-1] && id_legal(m_slave_id[m-1])) begin
                    found = 1; own = m; own_slave = int'(m_slave_id[m-1]);
                    held = 0; last = m;
                end
            end
        end
    endtask

    task automatic step();
        int prev_own;
        logic [1:0] exp_grant;
        prev_own = own;
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        exp_grant = (own != 0) ? 2'(1 << (own - 1)) : 2'b00;
        check_eq("grant",  32'(m_grant), 32'(exp_grant));
        check_eq("err",    32'(m_err),   32'(exp_err));
        check_eq("master", 32'(master),  own);
        check_eq("slave",  32'(slave),   (own != 0) ? own_slave : 0);
        if (own != 0 && prev_own == 0)
            $display("cycle %0d: grant M%0d -> S%0d", cycle, own, own_slave);
        if (exp_err != 0)
            $display("cycle %0d: err pulse %b", cycle, exp_err);
    endtask

    task automatic do_reset();
        rstN = 1'b0; m_req = '0; m_done = '0;
        step(); step();
        rstN = 1'b1;
    endtask

    int hold_cnt;
    int owners[$];

    initial begin
        // 1: reset held with both requesting, then M1 first
        rstN = 1'b0; m_req = 2'b11; m_slave_id[0] = 3'd1; m_slave_id[1] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_rst_master", 32'(master), 0);
        end
        rstN = 1'b1;
        step();
        check_eq("t1_first_master", 32'(master), 1);

        // 2: single M2 request to S3, release after a few cycles
        do_reset();
        m_req = 2'b10; m_slave_id[1] = 3'd3;
        step();
        check_eq("t2_master", 32'(master), 2);
        check_eq("t2_slave",  32'(slave),  3);
        m_req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        m_done = 2'b10;
        step();
        m_done = 2'b00;
        check_eq("t2_released", 32'(master), 0);
        step(); step();

        // 3: both requesting continuously, each holds 4 cycles
        do_reset();
        m_req = 2'b11; m_slave_id[0] = 3'd1; m_slave_id[1] = 3'd2;
        hold_cnt = 0;
        owners.delete();
        for (int i = 0; i < 24; i++) begin
            int prev_master;
            prev_master = int'(master);
            step();
            if (master != 0 && prev_master == 0) owners.push_back(int'(master));
            hold_cnt = (m_grant != 0) ? hold_cnt + 1 : 0;
            m_done = (hold_cnt == 4) ? m_grant : 2'b00;
        end
        m_done = 2'b00;
        check_eq("t3_owner_count", 32'(owners.size() >= 4), 1);
        if (owners.size() >= 4) begin
            check_eq("t3_owner0", owners[0], 1);
            check_eq("t3_owner1", owners[1], 2);
            check_eq("t3_owner2", owners[2], 1);
            check_eq("t3_owner3", owners[3], 2);
        end

        // 4: M1 with illegal ID, M2 legal in the same cycle
        do_reset();
        m_req = 2'b11; m_slave_id[0] = 3'd0; m_slave_id[1] = 3'd2;
        step();
        check_eq("t4_err",    32'(m_err),  32'(2'b01));
        check_eq("t4_master", 32'(master), 2);
        check_eq("t4_slave",  32'(slave),  2);
        step();
        m_done = 2'b10;
        step();
        m_done = 2'b00; m_req = 2'b00;
        step(); step();

        // 5: watchdog expiry, then release exactly on the last cycle
        do_reset();
        m_req = 2'b01; m_slave_id[0] = 3'd1;
        step();
        m_req = 2'b00;
        for (int i = 0; i < TO - 1; i++) step();
        check_eq("t5_still_owned", 32'(master), 1);
        step();
        check_eq("t5_timeout_err", 32'(m_err),  32'(2'b01));
        check_eq("t5_timeout_sel", 32'(master), 0);
        m_req = 2'b01;
        step(); step();
        m_req = 2'b00;
        for (int i = 0; i < TO - 1; i++) step();
        m_done = 2'b01;
        step();
        m_done = 2'b00;
        check_eq("t5_done_no_err", 32'(m_err),  0);
        check_eq("t5_done_sel",    32'(master), 0);
        step(); step();

        // 6: reset while M2 owns S1, then tie goes to M1
        do_reset();
        m_req = 2'b10; m_slave_id[1] = 3'd1;
        step();
        m_req = 2'b00;
        step(); step();
        rstN = 1'b0;
        step();
        check_eq("t6_rst_master", 32'(master), 0);
        check_eq("t6_rst_err",    32'(m_err),  0);
        rstN = 1'b1; m_req = 2'b11; m_slave_id[0] = 3'd1; m_slave_id[1] = 3'd2;
        step();
        check_eq("t6_tie_m1", 32'(master), 1);
        m_req = 2'b00; m_done = 2'b01;
        step();
        m_done = 2'b00;

        // random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            rstN = ($urandom_range(0, 149) != 0);
            for (int m = 0; m < NM; m++) begin
                if (!m_req[m]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        m_req[m] = 1'b1;
                        m_slave_id[m] = 3'($urandom_range(0, 4));
                    end
                end else if (m_grant[m] && $urandom_range(0, 1) == 0) begin
                    m_req[m] = 1'b0;
                end
                if ($urandom_range(0, 9) == 0) m_slave_id[m] = 3'($urandom_range(0, 4));
            end
            if (m_grant != 0 && $urandom_range(0, 5) == 0)
                m_done = m_grant;
            else if ($urandom_range(0, 9) == 0)
                m_done = 2'($urandom_range(0, 3));
            else
                m_done = 2'b00;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
